div_result_stage: RTL and testbench

- Registered output stage placed directly downstream of the combinational unsigned divider in the ALU pipeline.
- Captures the divider's unsigned quotient and remainder along with sign tags and a divide-by-zero tag from the operand stage.
- Applies signed fix-up (truncation toward zero) and drives results through a valid/ready handshake with a 2-entry skid buffer.
- Keeps saturating result and divide-by-zero event counters for the debug/CSR path.

---
 rtl/div_result_stage_if.sv | 18 +
 rtl/div_result_stage.sv | 77 +++++++
 tb/tb_div_result_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_result_stage_if.sv
// div_result_stage_if: divider result handshake and stats bundle.
interface div_result_stage_if #(parameter int N = 17, parameter int M = 9, parameter int CW = 16);
  logic          in_valid, in_ready, sign_a, sign_b, is_signed, div_zero;
  logic          out_valid, out_ready, dz_out;
  logic [N-1:0]  q_u;
  logic [M-1:0]  r_u;
  logic [N:0]    q_out;
  logic [M:0]    r_out;
  logic [CW-1:0] res_count, dz_count;
  modport master (
    output in_valid, q_u, r_u, sign_a, sign_b, is_signed, div_zero, out_ready,
    input  in_ready, out_valid, q_out, r_out, dz_out, res_count, dz_count
  );
  modport slave (
    input  in_valid, q_u, r_u, sign_a, sign_b, is_signed, div_zero, out_ready,
    output in_ready, out_valid, q_out, r_out, dz_out, res_count, dz_count
  );
endinterface

// File: rtl/div_result_stage.sv
// div_result_stage: signed fix-up of divider results behind a 2-entry skid buffer with stats counters.
module div_result_stage #(
  parameter int N  = 17,
  parameter int M  = 9,
  parameter int CW = 16
) (
  input logic               clk,
  input logic               rst_n,
  div_result_stage_if.slave io
);
  localparam int W = N + M + 3;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t        state_q, state_d;
  logic [W-1:0]  main_q, main_d, skid_q, skid_d, fix;
  logic [CW-1:0] res_q, res_d, dz_q, dz_d;
  logic [N:0]    q_ext, q_fix;
  logic [M:0]    r_ext, r_fix;
  logic          acc, tout;
  // Fix-up happens before storage so both entries hold final values
  always_comb begin
    q_ext = {1'b0, io.q_u};
    r_ext = {1'b0, io.r_u};
    q_fix = io.div_zero ? '1 : (io.is_signed && (io.sign_a ^ io.sign_b)) ? -q_ext : q_ext;
    r_fix = io.div_zero ? '0 : (io.is_signed && io.sign_a) ? -r_ext : r_ext;
    fix   = {q_fix, r_fix, io.div_zero};
  end
  assign acc  = io.in_valid && io.in_ready;
  assign tout = io.out_valid && io.out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (acc) begin
        main_d  = fix;
        state_d = ONE;
      end
      ONE: if (acc && !tout) begin
        skid_d  = fix;
        state_d = FULL;
      end else if (acc) begin
        main_d  = fix;
      end else if (tout) begin
        state_d = EMPTY;
      end
      FULL: if (tout) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    res_d = (tout && res_q != '1) ? res_q + 1'b1 : res_q;
    dz_d  = (tout && main_q[0] && dz_q != '1) ? dz_q + 1'b1 : dz_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      res_q   <= '0;
      dz_q    <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end
  assign io.out_valid = state_q != EMPTY;
  assign io.in_ready  = state_q != FULL;
  assign io.q_out     = main_q[W-1 -: N+1];
  assign io.r_out     = main_q[M+1 -: M+1];
  assign io.dz_out    = main_q[0];
  assign io.res_count = res_q;
  assign io.dz_count  = dz_q;
endmodule

// File: tb/tb_div_result_stage.sv
// tb_div_result_stage: directed and random checks of div_result_stage, plus a narrow-counter twin for saturation.
module tb_div_result_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  div_result_stage_if #(.N(17), .M(9), .CW(16)) io ();
  div_result_stage_if #(.N(17), .M(9), .CW(4))  io4 ();
  div_result_stage #(.N(17), .M(9), .CW(16)) dut  (.clk(clk), .rst_n(rst_n), .io(io));
  div_result_stage #(.N(17), .M(9), .CW(4))  dut4 (.clk(clk), .rst_n(rst_n), .io(io4));
  assign io4.in_valid  = io.in_valid;
  assign io4.q_u       = io.q_u;
  assign io4.r_u       = io.r_u;
  assign io4.sign_a    = io.sign_a;
  assign io4.sign_b    = io.sign_b;
  assign io4.is_signed = io.is_signed;
  assign io4.div_zero  = io.div_zero;
  assign io4.out_ready = io.out_ready;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [28:0] model(input logic [16:0] qu, input logic [8:0] ru,
                                        input logic sa, input logic sb, input logic s, input logic dz);
    int qi, ri;
    logic [17:0] qe;
    logic [9:0]  re;
    qi = int'(qu);
    ri = int'(ru);
    if (s && (sa ^ sb)) qi = -qi;
    if (s && sa) ri = -ri;
    qe = qi[17:0];
    re = ri[9:0];
    if (dz) begin
      qe = '1;
      re = '0;
    end
    return {qe, re, dz};
  endfunction
  task automatic put(input logic [16:0] q, input logic [8:0] r, input logic sa, input logic sb,
                     input logic s, input logic dz);
    io.q_u = q; io.r_u = r; io.sign_a = sa; io.sign_b = sb; io.is_signed = s; io.div_zero = dz;
    io.in_valid = 1'b1;
  endtask
  task automatic send(input logic [16:0] q, input logic [8:0] r, input logic sa, input logic sb,
                      input logic s, input logic dz);
    put(q, r, sa, sb, s, dz);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask
  initial begin
    logic [28:0] exp_q[$];
    logic [28:0] e;
    logic pend;
    int delivered, cyc, dz_exp;
    io.in_valid = 0; io.out_ready = 0; io.q_u = 0; io.r_u = 0;
    io.sign_a = 0; io.sign_b = 0; io.is_signed = 0; io.div_zero = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_in_ready", io.in_ready, 1);
    chk("rst_q_out", io.q_out, 0);
    chk("rst_counts", {io.res_count, io.dz_count}, 0);
    rst_n = 1'b1;
    io.out_ready = 1'b1;
    send(17'd100, 9'd3, 0, 0, 0, 0);
    chk("uns_valid", io.out_valid, 1);
    chk("uns_q", io.q_out, 100);
    chk("uns_r", io.r_out, 3);
    chk("uns_dz", io.dz_out, 0);
    @(negedge clk);
    chk("uns_res_count", io.res_count, 1);
    chk("uns_drained", io.out_valid, 0);
    send(17'd7, 9'd2, 1, 0, 1, 0);
    chk("sgn_neg_q", io.q_out, 18'h3FFF9);
    chk("sgn_neg_r", io.r_out, 10'h3FE);
    send(17'd7, 9'd2, 1, 1, 1, 0);
    chk("sgn_pos_q", io.q_out, 7);
    chk("sgn_pos_r", io.r_out, 10'h3FE);
    send(17'd7, 9'd2, 1, 0, 0, 0);
    chk("uns_tags_ignored", {io.q_out, io.r_out}, {18'd7, 10'd2});
    send(17'd0, 9'd0, 1, 0, 1, 0);
    chk("no_neg_zero", {io.q_out, io.r_out}, 0);
    send(17'h1ABCD, 9'd5, 1, 0, 1, 1);
    chk("dz_q", io.q_out, 18'h3FFFF);
    chk("dz_r", io.r_out, 0);
    chk("dz_flag", io.dz_out, 1);
    @(negedge clk);
    chk("dz_count", io.dz_count, 1);
    chk("res_count_6", io.res_count, 6);
    io.out_ready = 1'b0;
    put(17'd11, 9'd1, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_a_ready", io.in_ready, 1);
    chk("bp_a_out", io.q_out, 11);
    put(17'd12, 9'd2, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_full_ready", io.in_ready, 0);
    put(17'd13, 9'd3, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_hold_ready", io.in_ready, 0);
    chk("bp_hold_out", {io.q_out, io.r_out}, {18'd11, 10'd1});
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_out", {io.q_out, io.r_out}, {18'd12, 10'd2});
    chk("bp_b_ready", io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("bp_c_out", {io.q_out, io.r_out}, {18'd13, 10'd3});
    @(negedge clk);
    chk("bp_drained", io.out_valid, 0);
    chk("bp_res_count", io.res_count, 9);
    for (int i = 0; i < 5; i++) send(17'(i), 9'd0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_pre", io4.res_count, 14);
    for (int i = 0; i < 3; i++) send(17'(i), 9'd0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_hold", io4.res_count, 15);
    chk("sat_wide", io.res_count, 17);
    chk("sat_dz", io4.dz_count, 1);
    io.out_ready = 1'b0;
    send(17'd1, 9'd1, 0, 0, 0, 0);
    send(17'd2, 9'd2, 0, 0, 0, 0);
    chk("full_before_rst", io.in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", io.out_valid, 0);
    chk("mid_rst_ready", io.in_ready, 1);
    chk("mid_rst_counts", {io.res_count, io.dz_count}, 0);
    chk("mid_rst_counts4", {io4.res_count, io4.dz_count}, 0);
    rst_n = 1'b1;
    pend = 0; delivered = 0; cyc = 0; dz_exp = 0;
    while (delivered < 10000 && cyc < 60000) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        io.q_u = 17'($urandom); io.r_u = 9'($urandom);
        io.sign_a = 1'($urandom); io.sign_b = 1'($urandom); io.is_signed = 1'($urandom);
        io.div_zero = $urandom_range(0, 9) == 0;
        pend = 1;
      end
      io.in_valid = pend;
      io.out_ready = $urandom_range(0, 9) < 7;
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) chk("rnd_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rnd", {io.q_out, io.r_out, io.dz_out}, e);
          dz_exp += int'(e[0]);
        end
        delivered++;
      end
      if (pend && io.in_ready) begin
        exp_q.push_back(model(io.q_u, io.r_u, io.sign_a, io.sign_b, io.is_signed, io.div_zero));
        pend = 0;
      end
      @(negedge clk);
      cyc++;
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    chk("rnd_done", delivered, 10000);
    chk("rnd_res_count", io.res_count, 10000);
    chk("rnd_dz_count", io.dz_count, dz_exp);
    chk("rnd_sat4", io4.res_count, 15);
    chk("rnd_dz_sat4", io4.dz_count, dz_exp > 15 ? 15 : dz_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
